// File: rtl/logic_operand_queue_if.sv
// Request/issue bundle between the upstream source, the operand queue and the
// 4-bit logic units. The queue takes the slave modport; the driving side takes master.
interface logic_operand_queue_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_op;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [LW-1:0]    level;
  logic [CNTW-1:0]  issue_cnt;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, level, issue_cnt
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, level, issue_cnt
  );
endinterface

// File: rtl/logic_operand_queue.sv
// DEPTH-entry registered FIFO of {op, a, b} requests feeding the 4-bit logic
// units; the head entry drives the unit operand inputs directly.
module logic_operand_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_operand_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both 1; a source holding valid=1 keeps its payload stable until accepted.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNTW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]       op_mem_q [DEPTH];
  logic [WIDTH-1:0] a_mem_q  [DEPTH];
  logic [WIDTH-1:0] b_mem_q  [DEPTH];

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Both flags come from level_q only, so out_ready never reaches in_ready.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    issue_cnt_d = issue_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      issue_cnt_d = issue_cnt_q + CNTW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Storage is cleared on reset so a discarded entry can never resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_q[i] <= '0;
        a_mem_q[i]  <= '0;
        b_mem_q[i]  <= '0;
      end
    end else if (push) begin
      op_mem_q[wr_ptr_q] <= bus.in_op;
      a_mem_q[wr_ptr_q]  <= bus.in_a;
      b_mem_q[wr_ptr_q]  <= bus.in_b;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_op    = out_valid ? op_mem_q[rd_ptr_q] : '0;
  assign bus.out_a     = out_valid ? a_mem_q[rd_ptr_q]  : '0;
  assign bus.out_b     = out_valid ? b_mem_q[rd_ptr_q]  : '0;
  assign bus.level     = level_q;
  assign bus.issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_logic_operand_queue.sv
// Directed and random stimulus for logic_operand_queue, checked against a
// queue-based reference model of the FIFO and its issue counter.
module tb_logic_operand_queue;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNTW  = 8;
  localparam int W     = 2 + 2 * WIDTH;

  logic clk;
  logic rst_n;

  logic_operand_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  logic_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0]    exp_q[$];
  logic [CNTW-1:0] exp_cnt;
  logic [CNTW-1:0] cnt0;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference model's view of the queue.
  task automatic check_all(input string tag);
    logic [W-1:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, ".level"},     32'(bus.level),     32'(exp_q.size()));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(exp_q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() > 0));
    chk({tag, ".out_op"},    32'(bus.out_op),    32'(h[W-1:2*WIDTH]));
    chk({tag, ".out_a"},     32'(bus.out_a),     32'(h[2*WIDTH-1:WIDTH]));
    chk({tag, ".out_b"},     32'(bus.out_b),     32'(h[WIDTH-1:0]));
    chk({tag, ".issue_cnt"}, 32'(bus.issue_cnt), 32'(exp_cnt));
  endtask

  // Driver: called just after a falling edge, returns just after the next one.
  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic rdy);
    logic do_push;
    logic do_pop;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
    check_all(tag);
    do_push = v && (exp_q.size() < DEPTH);
    do_pop  = rdy && (exp_q.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      void'(exp_q.pop_front());
      exp_cnt = exp_cnt + CNTW'(1);
    end
    if (do_push) exp_q.push_back({op, a, b});
    @(negedge clk);
  endtask

  task automatic rand_step(input string tag, input logic v, input logic rdy);
    step(tag, v, 2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 15)),
         WIDTH'($urandom_range(0, 15)), rdy);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (exp_q.size() > 0) step(tag, 1'b0, 2'b00, '0, '0, 1'b1);
    end
    chk({tag, ".drained"}, 32'(bus.level), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    exp_cnt       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset release
    for (int i = 0; i < 10; i++) step("t1_idle", 1'b0, 2'b00, '0, '0, 1'b0);

    // 2: single OR request, visible one cycle later and consumed
    step("t2_push", 1'b1, 2'b00, 4'h5, 4'hA, 1'b1);
    chk("t2_or_unit", 32'(bus.out_a | bus.out_b), 32'hF);
    step("t2_pop", 1'b0, 2'b00, '0, '0, 1'b1);
    chk("t2_issue_cnt", 32'(bus.issue_cnt), 32'd1);
    step("t2_after", 1'b0, 2'b00, '0, '0, 1'b0);

    // 3: fill while stalled, third request held until space frees
    step("t3_req1", 1'b1, 2'b01, 4'h1, 4'h2, 1'b0);
    step("t3_req2", 1'b1, 2'b10, 4'h3, 4'h4, 1'b0);
    chk("t3_full_level", 32'(bus.level), 32'd2);
    chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
    step("t3_hold0", 1'b1, 2'b11, 4'h6, 4'h7, 1'b0);
    step("t3_hold1", 1'b1, 2'b11, 4'h6, 4'h7, 1'b0);
    step("t3_pop1",  1'b1, 2'b11, 4'h6, 4'h7, 1'b1);
    chk("t3_ready_after_pop", 32'(bus.in_ready), 32'd1);
    step("t3_accept", 1'b1, 2'b11, 4'h6, 4'h7, 1'b1);
    drain("t3_drain");

    // 4: steady push+pop at level 1, pointers wrap
    rand_step("t4_prime", 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_step("t4_stream", 1'b1, 1'b1);
      chk("t4_level", 32'(bus.level), 32'd1);
    end
    drain("t4_drain");

    // 5: 256 pops wrap the issue counter back to its start value
    cnt0 = exp_cnt;
    rand_step("t5_prime", 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) rand_step("t5_stream", 1'b1, 1'b1);
    drain("t5_drain");
    chk("t5_cnt_wrap", 32'(bus.issue_cnt), 32'(cnt0));

    // 6: asynchronous reset while full
    rand_step("t6_fill0", 1'b1, 1'b0);
    rand_step("t6_fill1", 1'b1, 1'b0);
    chk("t6_full", 32'(bus.level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_level",     32'(bus.level),     32'd0);
    chk("t6_async_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t6_async_out_a",     32'(bus.out_a),     32'd0);
    chk("t6_async_out_b",     32'(bus.out_b),     32'd0);
    chk("t6_async_issue_cnt", 32'(bus.issue_cnt), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("t6_post_idle", 1'b0, 2'b00, '0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
